// File: rtl/port_flit_sender_if.sv
// Source, arbiter and output signals of one router input-port flit sender.
// master = the sender block, slave = the surrounding source/arbiter/sink side.
interface port_flit_sender_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_id;
  logic [11:0]       in_length;
  logic [DATA_W-1:0] in_data;
  logic              req;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic              grant;
  logic              out_valid;
  logic [2:0]        out_id;
  logic [DATA_W-1:0] out_data;
  logic              err;

  modport master (
    input  in_valid, in_id, in_length, in_data, grant,
    output in_ready, req, flit_id, length, out_valid, out_id, out_data, err
  );

  modport slave (
    output in_valid, in_id, in_length, in_data, grant,
    input  in_ready, req, flit_id, length, out_valid, out_id, out_data, err
  );
endinterface

// File: rtl/port_flit_sender.sv
// Per-input-port flit sender: FIFO-buffers source flits, requests the arbiter, streams while granted.
// Optional SENDER_STATS_EN adds pkt_cnt / preempt_cnt saturating counters.
module port_flit_sender #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  port_flit_sender_if.master bus
`ifdef SENDER_STATS_EN
  ,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        preempt_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic [1:0] {IDLE, REQ, SEND, HOLD} state_t;
  state_t state_reg, state_next;

  logic [2:0]        id_mem   [DEPTH];
  logic [11:0]       len_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [AW:0]       count_reg, count_next, remain_cnt;
  logic [DEPTH-1:0]  slot_we;
  logic              push, pop, send, empty;
  logic [2:0]        head_id, head_next_id;
  logic              head_legal;

  logic              req_reg, req_next;
  logic [2:0]        flit_id_reg, flit_id_next;
  logic [11:0]       length_reg, length_next;
  logic              out_valid_reg, out_valid_next;
  logic [2:0]        out_id_reg, out_id_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic              err_reg, err_next;
  logic              len_load, len_clear;

  assign empty       = (count_reg == '0);
  assign bus.in_ready = (count_reg != FULL_CNT);
  assign push        = bus.in_valid && bus.in_ready;
  assign head_id     = id_mem[rd_ptr_reg];
  assign head_legal  = (head_id == ID_HDR) || (head_id == ID_BODY) || (head_id == ID_TAIL);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
    assign slot_we[gi] = push && (wr_ptr_reg == AW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) begin
        id_mem[i]   <= bus.in_id;
        len_mem[i]  <= bus.in_length;
        data_mem[i] <= bus.in_data;
      end
    end
  end

  // Head as seen after this edge, so flit_id can be registered without lagging the FIFO.
  assign rd_ptr_next  = rd_ptr_reg + AW'(pop);
  assign remain_cnt   = count_reg - (AW+1)'(pop);
  assign count_next   = remain_cnt + (AW+1)'(push);
  assign head_next_id = (remain_cnt == '0) ? bus.in_id : id_mem[rd_ptr_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Illegal codes are dropped in any state; grant is only honoured once a packet is requested.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    send       = 1'b0;
    err_next   = 1'b0;
    len_load   = 1'b0;
    len_clear  = 1'b0;
    if (!empty) begin
      if (!head_legal) begin
        pop      = 1'b1;
        err_next = 1'b1;
      end else if (state_reg == IDLE) begin
        if (head_id == ID_HDR) begin
          state_next = REQ;
          len_load   = 1'b1;
        end else begin
          pop      = 1'b1;
          err_next = 1'b1;
        end
      end else if (!bus.grant) begin
        if (state_reg == SEND) state_next = HOLD;
      end else if (head_id == ID_HDR && state_reg != REQ) begin
        err_next   = 1'b1;
        len_clear  = 1'b1;
        state_next = IDLE;
      end else begin
        pop  = 1'b1;
        send = 1'b1;
        if (head_id == ID_TAIL) begin
          state_next = IDLE;
          len_clear  = 1'b1;
        end else begin
          state_next = SEND;
        end
      end
    end else if (state_reg == SEND && !bus.grant) begin
      state_next = HOLD;
    end
  end

  always_comb begin
    req_next       = (state_next != IDLE);
    flit_id_next   = (req_next && count_next != '0) ? head_next_id : 3'b000;
    length_next    = len_load ? len_mem[rd_ptr_reg] : (len_clear ? 12'd0 : length_reg);
    out_valid_next = send;
    out_id_next    = send ? head_id : 3'b000;
    out_data_next  = send ? data_mem[rd_ptr_reg] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      req_reg       <= 1'b0;
      flit_id_reg   <= 3'b000;
      length_reg    <= 12'd0;
      out_valid_reg <= 1'b0;
      out_id_reg    <= 3'b000;
      out_data_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_reg + AW'(push);
      count_reg     <= count_next;
      req_reg       <= req_next;
      flit_id_reg   <= flit_id_next;
      length_reg    <= length_next;
      out_valid_reg <= out_valid_next;
      out_id_reg    <= out_id_next;
      out_data_reg  <= out_data_next;
      err_reg       <= err_next;
    end
  end

  assign bus.req       = req_reg;
  assign bus.flit_id   = flit_id_reg;
  assign bus.length    = length_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.err       = err_reg;

`ifdef SENDER_STATS_EN
  logic [15:0] pkt_cnt_reg, preempt_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_reg     <= 16'd0;
      preempt_cnt_reg <= 16'd0;
    end else begin
      if (send && head_id == ID_TAIL && pkt_cnt_reg != 16'hFFFF)
        pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
      if (state_reg == SEND && state_next == HOLD && preempt_cnt_reg != 16'hFFFF)
        preempt_cnt_reg <= preempt_cnt_reg + 16'd1;
    end
  end

  assign pkt_cnt     = pkt_cnt_reg;
  assign preempt_cnt = preempt_cnt_reg;
`endif
endmodule

// File: tb/tb_port_flit_sender.sv
// Randomized self-checking bench for port_flit_sender against a queue-based packet model.
module tb_port_flit_sender;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  typedef struct packed {
    logic [2:0]  id;
    logic [11:0] len;
    logic [31:0] data;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  port_flit_sender_if #(.DATA_W(DATA_W)) bus ();
`ifdef SENDER_STATS_EN
  logic [15:0] pkt_cnt, preempt_cnt;
`endif

  port_flit_sender #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SENDER_STATS_EN
    ,
    .pkt_cnt(pkt_cnt),
    .preempt_cnt(preempt_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: buffered flits, whether a packet is requested, whether its header left, whether it is streaming.
  flit_t       mq[$];
  flit_t       gen_q[$];
  bit          m_open, m_started, m_sending;
  logic [11:0] m_len;
  int          m_pkt, m_pre;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_open = 0; m_started = 0; m_sending = 0;
    m_len = 12'd0; m_pkt = 0; m_pre = 0;
  endtask

  task automatic close_pkt();
    m_open = 0; m_started = 0; m_sending = 0; m_len = 12'd0;
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.in_id = 0; bus.in_length = 0; bus.in_data = 0; bus.grant = 0;
    rst = 1'b1;
    #1;
    check_val("rst_req",       64'(bus.req),       64'd0);
    check_val("rst_flit_id",   64'(bus.flit_id),   64'd0);
    check_val("rst_length",    64'(bus.length),    64'd0);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_id",    64'(bus.out_id),    64'd0);
    check_val("rst_out_data",  64'(bus.out_data),  64'd0);
    check_val("rst_err",       64'(bus.err),       64'd0);
    check_val("rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef SENDER_STATS_EN
    check_val("rst_pkt_cnt",     64'(pkt_cnt),     64'd0);
    check_val("rst_preempt_cnt", 64'(preempt_cnt), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, advance the model by the packet rules, compare every output.
  task automatic step(input bit v, input flit_t f, input bit g, output bit acc);
    flit_t h;
    bit    e_ov, e_err;
    logic [2:0]  e_oid, e_fid;
    logic [31:0] e_od;
    bus.in_valid = v; bus.in_id = f.id; bus.in_length = f.len; bus.in_data = f.data; bus.grant = g;
    acc = v && (mq.size() < DEPTH);
    @(posedge clk);
    e_ov = 0; e_err = 0; e_oid = 3'b000; e_od = 32'd0;
    if (mq.size() > 0) begin
      h = mq[0];
      if (!(h.id inside {HDR, BODY, TAIL})) begin
        void'(mq.pop_front()); e_err = 1;
      end else if (!m_open) begin
        if (h.id == HDR) begin m_open = 1; m_len = h.len; end
        else begin void'(mq.pop_front()); e_err = 1; end
      end else if (!g) begin
        if (m_sending) begin m_sending = 0; m_pre++; end
      end else if (h.id == HDR && m_started) begin
        e_err = 1; close_pkt();
      end else begin
        void'(mq.pop_front());
        e_ov = 1; e_oid = h.id; e_od = h.data;
        if (h.id == TAIL) begin close_pkt(); m_pkt++; end
        else begin m_started = 1; m_sending = 1; end
      end
    end else if (m_open && m_sending && !g) begin
      m_sending = 0; m_pre++;
    end
    if (acc) mq.push_back(f);
    e_fid = (m_open && mq.size() > 0) ? mq[0].id : 3'b000;
    #1;
    check_val("req",       64'(bus.req),       64'(m_open));
    check_val("flit_id",   64'(bus.flit_id),   64'(e_fid));
    check_val("length",    64'(bus.length),    64'(m_len));
    check_val("out_valid", 64'(bus.out_valid), 64'(e_ov));
    check_val("out_id",    64'(bus.out_id),    64'(e_oid));
    if (e_ov) check_val("out_data", 64'(bus.out_data), 64'(e_od));
    check_val("err",       64'(bus.err),       64'(e_err));
    check_val("in_ready",  64'(bus.in_ready),  64'(mq.size() < DEPTH));
`ifdef SENDER_STATS_EN
    check_val("pkt_cnt",     64'(pkt_cnt),     64'(m_pkt));
    check_val("preempt_cnt", 64'(preempt_cnt), 64'(m_pre));
`endif
    if (e_ov)  $display("tx id=%b data=%h req=%0b len=%0d", e_oid, e_od, m_open, m_len);
    if (e_err) $display("err pulse at %0t", $time);
  endtask

  function automatic flit_t mk(input logic [2:0] id, input logic [11:0] len);
    flit_t f;
    f.id = id; f.len = len; f.data = $urandom;
    return f;
  endfunction

  task automatic push1(input logic [2:0] id, input logic [11:0] len, input bit g);
    bit acc;
    step(1'b1, mk(id, len), g, acc);
  endtask

  task automatic idle(input int n, input bit g);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, mk(3'b000, 12'd0), g, acc);
  endtask

  task automatic refill();
    int nb;
    nb = $urandom_range(0, 5);
    gen_q.push_back(mk(HDR, 12'($urandom)));
    for (int i = 0; i < nb; i++) gen_q.push_back(mk(BODY, 12'($urandom)));
    if ($urandom_range(0, 9) != 0) gen_q.push_back(mk(TAIL, 12'($urandom)));
    if ($urandom_range(0, 7) == 0) gen_q[$urandom_range(0, gen_q.size() - 1)].id = 3'($urandom);
  endtask

  initial begin
    bit acc, g;
    model_clear();
    bus.in_valid = 0; bus.in_id = 0; bus.in_length = 0; bus.in_data = 0; bus.grant = 0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset in the middle of a buffered packet.
    push1(HDR, 12'd3, 0); push1(BODY, 12'd0, 0); push1(BODY, 12'd0, 0);
    do_reset();
    idle(2, 1);

    // Basic three-flit packet.
    push1(HDR, 12'd5, 0); push1(BODY, 12'd0, 0); push1(TAIL, 12'd0, 0);
    check_val("basic_length", 64'(bus.length), 64'd5);
    idle(6, 1);

    // Preemption after two flits.
    push1(HDR, 12'd9, 0);
    for (int i = 0; i < 4; i++) push1(BODY, 12'd0, 0);
    push1(TAIL, 12'd0, 0);
    idle(2, 1); idle(4, 0); idle(6, 1);

    // FIFO full, then simultaneous push and pop.
    do_reset();
    push1(HDR, 12'd20, 0);
    for (int i = 0; i < 7; i++) push1(BODY, 12'd0, 0);
    check_val("full_in_ready", 64'(bus.in_ready), 64'd0);
    push1(BODY, 12'd0, 0);
    push1(BODY, 12'd0, 1); push1(BODY, 12'd0, 1); push1(TAIL, 12'd0, 1);
    idle(12, 1);

    // Protocol errors: stray body, then header mid-packet.
    push1(BODY, 12'd0, 0);
    idle(2, 0);
    push1(HDR, 12'd4, 1); push1(BODY, 12'd0, 1); push1(HDR, 12'd7, 1);
    push1(BODY, 12'd0, 1); push1(TAIL, 12'd0, 1);
    idle(6, 1);
    push1(3'b111, 12'd0, 1);
    idle(2, 1);

    // Underflow stall on a header-only packet.
    push1(HDR, 12'd11, 1);
    idle(5, 1);
    push1(TAIL, 12'd0, 1);
    idle(3, 1);

    // Random traffic with bursty grant.
    g = 0;
    for (int c = 0; c < 1500; c++) begin
      if (gen_q.size() == 0) refill();
      if ($urandom_range(0, 5) == 0) g = !g;
      step($urandom_range(0, 9) < 7, gen_q[0], g, acc);
      if (acc) void'(gen_q.pop_front());
    end
    idle(40, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
